// File: rtl/y86_pkg.sv
// Shared Y86 condition-code types and constants.
// Optional feature macro used by cc_cond_unit: CC_BYPASS_EN.
package y86_pkg;

    // jXX / cmovXX function codes
    localparam int unsigned C_YES = 0;
    localparam int unsigned C_LE  = 1;
    localparam int unsigned C_L   = 2;
    localparam int unsigned C_E   = 3;
    localparam int unsigned C_NE  = 4;
    localparam int unsigned C_GE  = 5;
    localparam int unsigned C_G   = 6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    typedef enum logic {
        CC_INIT = 1'b0,
        CC_LIVE = 1'b1
    } cc_state_e;

endpackage

// File: rtl/cc_cond_eval.sv
// Combinational jXX/cmovXX condition evaluator over a set of condition codes.
module cc_cond_eval
    import y86_pkg::*;
#(
    parameter int unsigned IFUN_W = 4
) (
    input  cc_t               cc,
    input  logic [IFUN_W-1:0] ifun,
    output logic              cnd,
    output logic              illegal
);

    logic lt;

    assign lt = cc.sf ^ cc.of;

    // Decode the function code; anything past C_G is not a condition
    always_comb begin
        cnd     = 1'b0;
        illegal = 1'b0;
        case (ifun)
            IFUN_W'(C_YES): cnd = 1'b1;
            IFUN_W'(C_LE):  cnd = lt | cc.zf;
            IFUN_W'(C_L):   cnd = lt;
            IFUN_W'(C_E):   cnd = cc.zf;
            IFUN_W'(C_NE):  cnd = ~cc.zf;
            IFUN_W'(C_GE):  cnd = ~lt;
            IFUN_W'(C_G):   cnd = ~lt & ~cc.zf;
            default:        illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cc_cond_unit.sv
// Y86 SEQ Execute condition-code register and condition evaluation.
// Define CC_BYPASS_EN to evaluate conditions on the flags being written
// this cycle instead of the registered ones.
module cc_cond_unit
    import y86_pkg::*;
#(
    parameter int unsigned W      = 64,
    parameter int unsigned IFUN_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_cc,
    input  logic              stall,
    input  logic              exc,
    input  logic [W-1:0]      alu_result,
    input  logic              alu_overflow,
    input  logic              cond_req,
    input  logic [IFUN_W-1:0] ifun,
    output logic              zf,
    output logic              sf,
    output logic              of,
    output logic              cc_live,
    output logic              cnd,
    output logic              cond_err
);

    cc_t       cc_q, cc_d, cc_new, eval_cc;
    cc_state_e state_q, state_d;
    logic      upd;
    logic      eval_cnd, eval_illegal;

    assign upd    = set_cc & ~stall & ~exc;
    assign cc_new = '{zf: (alu_result == '0), sf: alu_result[W-1], of: alu_overflow};

    // Next flag value: load from the ALU only on an unblocked update
    always_comb begin
        cc_d = cc_q;
        if (upd) begin
            cc_d = cc_new;
        end
    end

    // Flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= CC_RESET;
        end else begin
            cc_q <= cc_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CC_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the first accepted update makes the flags live
    always_comb begin
        state_d = state_q;
        case (state_q)
            CC_INIT: if (upd) state_d = CC_LIVE;
            CC_LIVE: state_d = CC_LIVE;
            default: state_d = CC_INIT;
        endcase
    end

    // FSM output decode
    always_comb begin
        cc_live = 1'b0;
        if (state_q == CC_LIVE) begin
            cc_live = 1'b1;
        end
    end

`ifdef CC_BYPASS_EN
    assign eval_cc = upd ? cc_new : cc_q;
`else
    assign eval_cc = cc_q;
`endif

    cc_cond_eval #(
        .IFUN_W (IFUN_W)
    ) u_eval (
        .cc      (eval_cc),
        .ifun    (ifun),
        .cnd     (eval_cnd),
        .illegal (eval_illegal)
    );

    assign cnd      = cond_req & eval_cnd;
    assign cond_err = cond_req & eval_illegal;

    assign zf = cc_q.zf;
    assign sf = cc_q.sf;
    assign of = cc_q.of;

endmodule
